reg_wb_arbiter: RTL and testbench

//  - Shares the register file's single write port among 3 writeback requesters:
//    0 = ALU result, 1 = memory load, 2 = JAL link (PC+4 to $31).
//  - Each requester feeds a small per-port FIFO. One entry per cycle drives the registered

---
 rtl/reg_wb_arbiter.sv | 177 +++++++++++++++++
 tb/tb_reg_wb_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - writeback arbiter: three per-requester FIFOs sharing one register file write port
// Optional round-robin arbitration with WB_ARB_RR_EN; fixed priority req0 > req1 > req2 otherwise.
module reg_wb_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [2:0]            req_valid_i,
   output logic [2:0]            req_ready_o,
   input  logic [3*ADDR_W-1:0]   req_addr_i,
   input  logic [3*DATA_W-1:0]   req_data_i,
   input  logic [ADDR_W-1:0]     RSaddr_i,
   input  logic [ADDR_W-1:0]     RTaddr_i,
   output logic                  RegWrite_o,
   output logic [ADDR_W-1:0]     RDaddr_o,
   output logic [DATA_W-1:0]     RDdata_o,
   output logic [2:0]            grant_o,
   output logic                  hazard_o,
   output logic                  busy_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [ADDR_W-1:0] fa_q [3][FIFO_DEPTH];
   logic [DATA_W-1:0] fd_q [3][FIFO_DEPTH];
   logic [PW-1:0]     wp_q [3];
   logic [PW-1:0]     rp_q [3];
   logic [CW-1:0]     cnt_q [3];

   logic [2:0]        full;
   logic [2:0]        nonempty;
   logic [2:0]        push;
   logic [2:0]        grant_d;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_data;

   logic              regwrite_q;
   logic [ADDR_W-1:0] rdaddr_q;
   logic [DATA_W-1:0] rddata_q;
   logic [2:0]        grant_q;

   always_comb begin
      full     = '0;
      nonempty = '0;
      for (int k = 0; k < 3; k++) begin
         full[k]     = (cnt_q[k] == CW'(FIFO_DEPTH));
         nonempty[k] = (cnt_q[k] != '0);
      end
   end

   assign req_ready_o = ~full;
   assign push        = req_valid_i & ~full;

`ifdef WB_ARB_RR_EN
   logic [1:0] rr_q;
   logic [1:0] rr_d;
   logic [2:0] sum;
   logic [1:0] idx;
   logic       found;

   // Search starts at rr_q and wraps modulo 3; pointer only moves on a grant.
   always_comb begin
      grant_d = '0;
      rr_d    = rr_q;
      found   = 1'b0;
      sum     = '0;
      idx     = '0;
      for (int i = 0; i < 3; i++) begin
         sum = {1'b0, rr_q} + 3'(i);
         idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
         if (!found && nonempty[idx]) begin
            grant_d[idx] = 1'b1;
            rr_d         = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            found        = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) rr_q <= '0;
      else       rr_q <= rr_d;
   end
`else
   always_comb begin
      grant_d    = '0;
      grant_d[0] = nonempty[0];
      grant_d[1] = nonempty[1] & ~nonempty[0];
      grant_d[2] = nonempty[2] & ~(|nonempty[1:0]);
   end
`endif

   always_comb begin
      win_addr = '0;
      win_data = '0;
      for (int k = 0; k < 3; k++) begin
         if (grant_d[k]) begin
            win_addr = fa_q[k][rp_q[k]];
            win_data = fd_q[k][rp_q[k]];
         end
      end
   end

   // Storage needs no reset: validity is carried entirely by the counts.
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < 3; k++) begin
         if (push[k]) begin
            fa_q[k][wp_q[k]] <= req_addr_i[k*ADDR_W +: ADDR_W];
            fd_q[k][wp_q[k]] <= req_data_i[k*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < 3; k++) begin
            wp_q[k]  <= '0;
            rp_q[k]  <= '0;
            cnt_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (push[k])    wp_q[k] <= wp_q[k] + PW'(1);
            if (grant_d[k]) rp_q[k] <= rp_q[k] + PW'(1);
            cnt_q[k] <= cnt_q[k] + CW'(push[k]) - CW'(grant_d[k]);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         regwrite_q <= 1'b0;
         rdaddr_q   <= '0;
         rddata_q   <= '0;
         grant_q    <= '0;
      end else begin
         grant_q    <= grant_d;
         regwrite_q <= (|grant_d) && (win_addr != '0);
         if (|grant_d) begin
            rdaddr_q <= win_addr;
            rddata_q <= win_data;
         end
      end
   end

   assign RegWrite_o = regwrite_q;
   assign RDaddr_o   = rdaddr_q;
   assign RDdata_o   = rddata_q;
   assign grant_o    = grant_q;
   assign busy_o     = (|nonempty) | regwrite_q;

   // An entry is live when its offset from the read pointer is below the count.
   always_comb begin
      logic [PW-1:0]     off;
      logic [ADDR_W-1:0] a;
      hazard_o = 1'b0;
      off      = '0;
      a        = '0;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            off = PW'(i) - rp_q[k];
            a   = fa_q[k][i];
            if ({1'b0, off} < cnt_q[k]) begin
               if ((RSaddr_i != '0 && RSaddr_i == a) || (RTaddr_i != '0 && RTaddr_i == a))
                  hazard_o = 1'b1;
            end
         end
      end
      if (regwrite_q) begin
         if ((RSaddr_i != '0 && RSaddr_i == rdaddr_q) || (RTaddr_i != '0 && RTaddr_i == rdaddr_q))
            hazard_o = 1'b1;
      end
   end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - directed and random checks of reg_wb_arbiter against a queue model
module tb_reg_wb_arbiter;

   localparam int D = 2;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic [2:0]   req_valid_i = '0;
   logic [2:0]   req_ready_o;
   logic [14:0]  req_addr_i = '0;
   logic [95:0]  req_data_i = '0;
   logic [4:0]   RSaddr_i = '0;
   logic [4:0]   RTaddr_i = '0;
   logic         RegWrite_o;
   logic [4:0]   RDaddr_o;
   logic [31:0]  RDdata_o;
   logic [2:0]   grant_o;
   logic         hazard_o;
   logic         busy_o;

   int checks = 0;
   int errors = 0;

   logic [4:0]  mqa [3][$];
   logic [31:0] mqd [3][$];
   logic        exp_we    = 1'b0;
   logic [4:0]  exp_addr  = '0;
   logic [31:0] exp_data  = '0;
   logic [2:0]  exp_grant = '0;
   int          rr        = 0;

   reg_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(D)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_addr_i(req_addr_i), .req_data_i(req_data_i), .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i),
      .RegWrite_o(RegWrite_o), .RDaddr_o(RDaddr_o), .RDdata_o(RDdata_o), .grant_o(grant_o),
      .hazard_o(hazard_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_hazard(input logic [4:0] rs, input logic [4:0] rt);
      logic h = 1'b0;
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < mqa[k].size(); i++)
            if ((rs != 0 && rs == mqa[k][i]) || (rt != 0 && rt == mqa[k][i])) h = 1'b1;
      if (exp_we && ((rs != 0 && rs == exp_addr) || (rt != 0 && rt == exp_addr))) h = 1'b1;
      return h;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         mqa[k].delete();
         mqd[k].delete();
      end
      exp_we = 1'b0; exp_addr = '0; exp_data = '0; exp_grant = '0; rr = 0;
   endtask

   // One clock cycle: drive, check combinational outputs, advance model, check registered outputs.
   task automatic step(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                       input logic [4:0] rs, input logic [4:0] rt);
      logic [2:0] rdy;
      logic       any;
      int         win;
      req_valid_i = v; req_addr_i = a; req_data_i = d; RSaddr_i = rs; RTaddr_i = rt;
      #1;
      any = exp_we;
      for (int k = 0; k < 3; k++) begin
         rdy[k] = (mqa[k].size() < D);
         if (mqa[k].size() != 0) any = 1'b1;
      end
      chk("ready", 64'(req_ready_o), 64'(rdy));
      chk("hazard", 64'(hazard_o), 64'(model_hazard(rs, rt)));
      chk("busy", 64'(busy_o), 64'(any));
      win = -1;
`ifdef WB_ARB_RR_EN
      for (int i = 0; i < 3; i++)
         if (win < 0 && mqa[(rr + i) % 3].size() != 0) win = (rr + i) % 3;
`else
      for (int k = 0; k < 3; k++)
         if (win < 0 && mqa[k].size() != 0) win = k;
`endif
      if (win >= 0) begin
         exp_addr  = mqa[win].pop_front();
         exp_data  = mqd[win].pop_front();
         exp_we    = (exp_addr != 0);
         exp_grant = 3'(1 << win);
         rr        = (win + 1) % 3;
      end else begin
         exp_we    = 1'b0;
         exp_grant = '0;
      end
      for (int k = 0; k < 3; k++)
         if (v[k] && rdy[k]) begin
            mqa[k].push_back(a[k*5 +: 5]);
            mqd[k].push_back(d[k*32 +: 32]);
         end
      @(posedge clk_i);
      #1;
      chk("regwrite", 64'(RegWrite_o), 64'(exp_we));
      chk("rdaddr", 64'(RDaddr_o), 64'(exp_addr));
      chk("rddata", 64'(RDdata_o), 64'(exp_data));
      chk("grant", 64'(grant_o), 64'(exp_grant));
   endtask

   task automatic idle(input logic [4:0] rs, input logic [4:0] rt);
      step(3'b000, '0, '0, rs, rt);
   endtask

   initial begin
      model_reset();
      #12;
      chk("rst_regwrite", 64'(RegWrite_o), 64'd0);
      chk("rst_grant", 64'(grant_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_ready", 64'(req_ready_o), 64'h7);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;

      // Single write on req0
      step(3'b001, {5'd0, 5'd0, 5'd8}, {32'd0, 32'd0, 32'hDEAD_BEEF}, 5'd0, 5'd0);
      idle(5'd0, 5'd0);
      chk("t2_regwrite", 64'(RegWrite_o), 64'd1);
      chk("t2_addr", 64'(RDaddr_o), 64'd8);
      chk("t2_data", 64'(RDdata_o), 64'hDEAD_BEEF);
      chk("t2_grant", 64'(grant_o), 64'b001);
      idle(5'd0, 5'd0);
      chk("t2_drop", 64'(RegWrite_o), 64'd0);

      // Contention
      step(3'b111, {5'd31, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 5'd0, 5'd0);
      idle(5'd0, 5'd0);
`ifndef WB_ARB_RR_EN
      chk("t3_g0", 64'(grant_o), 64'b001);
`endif
      idle(5'd0, 5'd0);
`ifndef WB_ARB_RR_EN
      chk("t3_g1", 64'(grant_o), 64'b010);
`endif
      idle(5'd0, 5'd0);
`ifndef WB_ARB_RR_EN
      chk("t3_g2", 64'(grant_o), 64'b100);
`endif
      idle(5'd0, 5'd0);
      idle(5'd0, 5'd0);

      // Full FIFO on req1 while req0 streams
      for (int i = 0; i < 3; i++)
         step(3'b011, {5'd0, 5'(12 + i), 5'(3 + i)}, {32'd0, 32'(32'hA0 + i), 32'(32'hB0 + i)}, 5'd0, 5'd0);
`ifndef WB_ARB_RR_EN
      chk("t4_ready", 64'(req_ready_o[1]), 64'd0);
`endif
      for (int i = 0; i < 6; i++) idle(5'd0, 5'd0);

      // Write to $0
      step(3'b100, {5'd0, 5'd0, 5'd0}, {32'd5, 32'd0, 32'd0}, 5'd0, 5'd0);
      idle(5'd0, 5'd0);
      chk("t5_grant", 64'(grant_o), 64'b100);
      chk("t5_regwrite", 64'(RegWrite_o), 64'd0);
      chk("t5_hazard", 64'(hazard_o), 64'd0);

      // Hazard tracking for addr 9
      step(3'b010, {5'd0, 5'd9, 5'd0}, {32'd0, 32'h99, 32'd0}, 5'd0, 5'd9);
      idle(5'd10, 5'd9);
      chk("t6_hz_out", 64'(hazard_o), 64'd1);
      idle(5'd10, 5'd0);
      idle(5'd0, 5'd9);

      // Async reset with two entries queued
      step(3'b110, {5'd7, 5'd6, 5'd0}, {32'h77, 32'h66, 32'd0}, 5'd0, 5'd0);
      req_valid_i = '0; RSaddr_i = 5'd7; RTaddr_i = 5'd0;
      #2;
      rst_i = 1'b1;
      #1;
      chk("t1_regwrite", 64'(RegWrite_o), 64'd0);
      chk("t1_grant", 64'(grant_o), 64'd0);
      chk("t1_busy", 64'(busy_o), 64'd0);
      chk("t1_hazard", 64'(hazard_o), 64'd0);
      chk("t1_ready", 64'(req_ready_o), 64'h7);
      model_reset();
      @(posedge clk_i);
      #3;
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      for (int i = 0; i < 3; i++) idle(5'd7, 5'd6);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [14:0] ra;
         logic [95:0] rd;
         for (int k = 0; k < 3; k++) begin
            ra[k*5 +: 5]   = 5'($urandom_range(0, 7));
            rd[k*32 +: 32] = $urandom;
         end
         step(3'($urandom), ra, rd, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
      for (int i = 0; i < 8; i++) idle(5'd0, 5'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
